// File: rtl/tram_console.sv
`default_nettype none
// ============================================================================
// Module   : tram_console
// Purpose  : Character-stream writer for text RAM. Accepts code points on a
//            valid/ready stream and handles CR, LF and BS. It writes glyph
//            words at the cursor, and keeps the cursor and a circular scroll
//            offset. The offset drives the textmode renderer.
// Options  : TRAM_CONSOLE_TAB_EN - when defined, 0x09 advances the cursor
//            to the next multiple of 8. When undefined, 0x09 is a glyph.
// Revision : 1.0 - initial release
// ============================================================================
module tram_console #(
  parameter int WORD      = 32,
  parameter int ADDRW     = 12,
  parameter int CIDXW     = 4,
  parameter int TRAM_HRES = 80,
  parameter int TRAM_VRES = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic [20:0]      char_ucp,
  input  logic [CIDXW-1:0] colr_fg,
  input  logic [CIDXW-1:0] colr_bg,
  input  logic             clear,
  output logic             tram_we,
  output logic [ADDRW-1:0] tram_addr,
  output logic [WORD-1:0]  tram_data,
  output logic [ADDRW-1:0] scroll_offs,
  output logic [ADDRW-1:0] cursor_x,
  output logic [ADDRW-1:0] cursor_y,
  output logic             busy
);

  localparam logic [ADDRW-1:0] c_hres      = ADDRW'(TRAM_HRES);
  localparam logic [ADDRW-1:0] c_hlast     = ADDRW'(TRAM_HRES - 1);
  localparam logic [ADDRW-1:0] c_vlast     = ADDRW'(TRAM_VRES - 1);
  localparam logic [ADDRW-1:0] c_last      = ADDRW'(TRAM_HRES * TRAM_VRES - 1);
  localparam logic [ADDRW-1:0] c_base_last = ADDRW'((TRAM_VRES - 1) * TRAM_HRES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_SCROLL = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  state_t           r_state, w_state_n;
  logic             r_we, w_we_n;
  logic [ADDRW-1:0] r_addr, w_addr_n;
  logic [WORD-1:0]  r_data, w_data_n;
  logic [ADDRW-1:0] r_offs, w_offs_n;
  logic [ADDRW-1:0] r_x, w_x_n;
  logic [ADDRW-1:0] r_y, w_y_n;
  logic [ADDRW-1:0] r_base, w_base_n;
  logic [ADDRW-1:0] r_cnt, w_cnt_n;
  logic [CIDXW-1:0] r_fg, w_fg_n;
  logic [CIDXW-1:0] r_bg, w_bg_n;
  logic             w_ready, w_accept, w_do_nl;
`ifdef TRAM_CONSOLE_TAB_EN
  logic [ADDRW-1:0] w_tab_x;
`endif

  // Tram word: {bg, fg, zero padding, code point}
  function automatic logic [WORD-1:0] f_word(input logic [CIDXW-1:0] bg,
                                             input logic [CIDXW-1:0] fg,
                                             input logic [20:0]      ucp);
    f_word = '0;
    f_word[20:0] = ucp;
    f_word[WORD-1 -: CIDXW] = bg;
    f_word[WORD-CIDXW-1 -: CIDXW] = fg;
  endfunction

  assign w_ready    = !rst && (r_state == S_IDLE) && !clear;
  assign w_accept   = char_valid && w_ready;
  assign char_ready = w_ready;
  assign busy       = (r_state != S_IDLE);
  assign tram_we    = r_we;
  assign tram_addr  = r_addr;
  assign tram_data  = r_data;
  assign scroll_offs = r_offs;
  assign cursor_x   = r_x;
  assign cursor_y   = r_y;

  // Next-state, cursor and write-port decode; write outputs are one cycle ahead
  always_comb begin
    w_state_n = r_state;
    w_we_n    = 1'b0;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_offs_n  = r_offs;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_base_n  = r_base;
    w_cnt_n   = r_cnt;
    w_fg_n    = r_fg;
    w_bg_n    = r_bg;
    w_do_nl   = 1'b0;
`ifdef TRAM_CONSOLE_TAB_EN
    w_tab_x   = (r_x | ADDRW'(7)) + ADDRW'(1);
`endif
    case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_state_n = S_CLEAR;
          w_fg_n    = colr_fg;
          w_bg_n    = colr_bg;
          w_cnt_n   = '0;
          w_we_n    = 1'b1;
          w_addr_n  = '0;
          w_data_n  = f_word(colr_bg, colr_fg, 21'h20);
        end else if (w_accept) begin
          w_fg_n = colr_fg;
          w_bg_n = colr_bg;
          case (char_ucp)
            21'h0D: w_x_n = '0;
            21'h0A: begin
              w_x_n   = '0;
              w_do_nl = 1'b1;
            end
            21'h08: begin
              if (r_x != '0) w_x_n = r_x - ADDRW'(1);
            end
`ifdef TRAM_CONSOLE_TAB_EN
            21'h09: begin
              if (w_tab_x >= c_hres) begin
                w_x_n   = '0;
                w_do_nl = 1'b1;
              end else begin
                w_x_n = w_tab_x;
              end
            end
`endif
            default: begin
              w_state_n = S_WRITE;
              w_we_n    = 1'b1;
              w_addr_n  = r_base + r_x;
              w_data_n  = f_word(colr_bg, colr_fg, char_ucp);
            end
          endcase
        end
      end
      S_WRITE: begin
        if (r_x < c_hlast) begin
          w_x_n     = r_x + ADDRW'(1);
          w_state_n = S_IDLE;
        end else begin
          w_x_n   = '0;
          w_do_nl = 1'b1;
        end
      end
      S_SCROLL: begin
        if (r_cnt == c_hlast) begin
          w_offs_n  = (r_offs == c_base_last) ? '0 : r_offs + c_hres;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n  = r_cnt + ADDRW'(1);
          w_we_n   = 1'b1;
          w_addr_n = r_base + r_cnt + ADDRW'(1);
          w_data_n = f_word(r_bg, r_fg, 21'h20);
        end
      end
      S_CLEAR: begin
        if (r_cnt == c_last) begin
          w_offs_n  = '0;
          w_x_n     = '0;
          w_y_n     = '0;
          w_base_n  = '0;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n  = r_cnt + ADDRW'(1);
          w_we_n   = 1'b1;
          w_addr_n = r_cnt + ADDRW'(1);
          w_data_n = f_word(r_bg, r_fg, 21'h20);
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Newline: step down a row, or on the bottom row recycle the top line and blank it
    if (w_do_nl) begin
      if (r_y == c_vlast) begin
        w_state_n = S_SCROLL;
        w_base_n  = r_offs;
        w_cnt_n   = '0;
        w_we_n    = 1'b1;
        w_addr_n  = r_offs;
        w_data_n  = f_word(w_bg_n, w_fg_n, 21'h20);
      end else begin
        w_state_n = S_IDLE;
        w_y_n     = r_y + ADDRW'(1);
        w_base_n  = (r_base == c_base_last) ? '0 : r_base + c_hres;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_offs  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_base  <= '0;
      r_cnt   <= '0;
      r_fg    <= '0;
      r_bg    <= '0;
    end else begin
      r_state <= w_state_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      r_offs  <= w_offs_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_base  <= w_base_n;
      r_cnt   <= w_cnt_n;
      r_fg    <= w_fg_n;
      r_bg    <= w_bg_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tram_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_tram_console
// Purpose  : Directed self-checking bench for tram_console (80x30, 32-bit word)
// Revision : 1.0 - initial release
// ============================================================================
module tb_tram_console;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [20:0] char_ucp = '0;
  logic [3:0]  colr_fg = '0;
  logic [3:0]  colr_bg = '0;
  logic        clear = 1'b0;
  logic        tram_we;
  logic [11:0] tram_addr;
  logic [31:0] tram_data;
  logic [11:0] scroll_offs;
  logic [11:0] cursor_x;
  logic [11:0] cursor_y;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  tram_console dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_ucp   (char_ucp),
    .colr_fg    (colr_fg),
    .colr_bg    (colr_bg),
    .clear      (clear),
    .tram_we    (tram_we),
    .tram_addr  (tram_addr),
    .tram_data  (tram_data),
    .scroll_offs(scroll_offs),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls
  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one code point; returns #1 into the cycle after it was accepted
  task automatic send(input logic [20:0] c);
    int n = 0;
    char_ucp   = c;
    char_valid = 1'b1;
    @(negedge clk);
    while (!char_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int cnt;

    // Reset state
    repeat (3) step();
    chk("rst_ready", 32'(char_ready), 32'd0);
    chk("rst_we", 32'(tram_we), 32'd0);
    chk("rst_addr", 32'(tram_addr), 32'd0);
    chk("rst_data", tram_data, 32'd0);
    chk("rst_offs", 32'(scroll_offs), 32'd0);
    chk("rst_cx", 32'(cursor_x), 32'd0);
    chk("rst_cy", 32'(cursor_y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // First glyph at home
    colr_fg = 4'd7; colr_bg = 4'd0;
    send(21'h41);
    chk("g1_we", 32'(tram_we), 32'd1);
    chk("g1_addr", 32'(tram_addr), 32'd0);
    chk("g1_data", tram_data, 32'h07000041);
    chk("g1_ready_wr", 32'(char_ready), 32'd0);
    step();
    chk("g1_cx", 32'(cursor_x), 32'd1);
    chk("g1_ready", 32'(char_ready), 32'd1);

    // CR back to home, then a full line of 'B'
    send(21'h0D);
    chk("cr0_we", 32'(tram_we), 32'd0);
    chk("cr0_cx", 32'(cursor_x), 32'd0);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      send(21'h42);
      if (!(tram_we === 1'b1 && tram_addr === 12'(i) && tram_data === 32'h07000042)) bad++;
    end
    chk("line_writes_bad", 32'(bad), 32'd0);
    step();
    chk("line_cx", 32'(cursor_x), 32'd0);
    chk("line_cy", 32'(cursor_y), 32'd1);
    chk("line_offs", 32'(scroll_offs), 32'd0);
    chk("line_busy", 32'(busy), 32'd0);

    // Backspace at x=0 and at x=5
    send(21'h08);
    chk("bs0_we", 32'(tram_we), 32'd0);
    chk("bs0_cx", 32'(cursor_x), 32'd0);
    for (int i = 0; i < 5; i++) send(21'h43);
    chk("c5_addr", 32'(tram_addr), 32'd84);
    send(21'h08);
    chk("bs5_we", 32'(tram_we), 32'd0);
    chk("bs5_cx", 32'(cursor_x), 32'd4);

    // CR at x=40
    for (int i = 0; i < 36; i++) send(21'h43);
    step();
    chk("x40_cx", 32'(cursor_x), 32'd40);
    send(21'h0D);
    chk("cr40_we", 32'(tram_we), 32'd0);
    chk("cr40_cx", 32'(cursor_x), 32'd0);
    chk("cr40_cy", 32'(cursor_y), 32'd1);

    // Walk down to the bottom row and to column 5
    for (int i = 0; i < 28; i++) send(21'h0A);
    chk("lf_cy", 32'(cursor_y), 32'd29);
    chk("lf_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) send(21'h44);
    chk("row29_addr", 32'(tram_addr), 32'd2324);
    step();

    // LF on the bottom row scrolls: blank the old top line
    colr_fg = 4'd7; colr_bg = 4'd1;
    send(21'h0A);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (!(tram_we === 1'b1 && tram_addr === 12'(i) && tram_data === 32'h17000020 && busy === 1'b1)) bad++;
      step();
    end
    chk("scroll_bad", 32'(bad), 32'd0);
    chk("scroll_we_end", 32'(tram_we), 32'd0);
    chk("scroll_offs", 32'(scroll_offs), 32'd80);
    chk("scroll_cx", 32'(cursor_x), 32'd0);
    chk("scroll_cy", 32'(cursor_y), 32'd29);
    chk("scroll_busy", 32'(busy), 32'd0);
    colr_fg = 4'd7; colr_bg = 4'd0;
    send(21'h41);
    chk("post_scroll_addr", 32'(tram_addr), 32'd0);
    chk("post_scroll_data", tram_data, 32'h07000041);

    // Second scroll (line 80..159), reset on its 10th cycle
    send(21'h0A);
    repeat (9) step();
    chk("scroll2_c10_addr", 32'(tram_addr), 32'd89);
    chk("scroll2_c10_we", 32'(tram_we), 32'd1);
    rst = 1'b1;
    step();
    chk("rstmid_we", 32'(tram_we), 32'd0);
    chk("rstmid_cx", 32'(cursor_x), 32'd0);
    chk("rstmid_cy", 32'(cursor_y), 32'd0);
    chk("rstmid_offs", 32'(scroll_offs), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Move off home, then clear with char_valid held high
    send(21'h5A);
    step();
    chk("pre_clear_cx", 32'(cursor_x), 32'd1);
    colr_fg = 4'd2; colr_bg = 4'd3;
    char_ucp = 21'h45; char_valid = 1'b1; clear = 1'b1;
    #1;
    chk("clear_ready", 32'(char_ready), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    bad = 0;
    cnt = 0;
    while (busy && cnt < 3000) begin
      if (!(tram_we === 1'b1 && tram_addr === 12'(cnt) && tram_data === 32'h32000020 && char_ready === 1'b0)) bad++;
      cnt++;
      step();
    end
    chk("clear_cycles", 32'(cnt), 32'd2400);
    chk("clear_bad", 32'(bad), 32'd0);
    chk("clear_ready_end", 32'(char_ready), 32'd1);
    chk("clear_offs", 32'(scroll_offs), 32'd0);
    chk("clear_cx", 32'(cursor_x), 32'd0);
    chk("clear_cy", 32'(cursor_y), 32'd0);
    step();
    char_valid = 1'b0;
    chk("post_clear_we", 32'(tram_we), 32'd1);
    chk("post_clear_addr", 32'(tram_addr), 32'd0);
    chk("post_clear_data", tram_data, 32'h32000045);
    step();

    // TAB handling (x=1 here)
    send(21'h09);
`ifdef TRAM_CONSOLE_TAB_EN
    chk("tab_we", 32'(tram_we), 32'd0);
    chk("tab_cx", 32'(cursor_x), 32'd8);
`else
    chk("tab_we", 32'(tram_we), 32'd1);
    chk("tab_addr", 32'(tram_addr), 32'd1);
    chk("tab_data", tram_data, 32'h32000009);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
